// File: rtl/internal_framebuffer_stream_loader_pkg.sv
// rtl/internal_framebuffer_stream_loader_pkg.sv - shared loader/memset state encodings and scissor test
package internal_framebuffer_stream_loader_pkg;

  typedef enum logic [1:0] {
    FB_IDLE  = 2'd0,
    FB_LOAD  = 2'd1,
    FB_DRAIN = 2'd2
  } fb_state_e;

  // Coordinates are zero-extended to this width before comparison so the
  // x+i pixel offset within a beat cannot wrap.
  localparam int COORD_W = 16;

  // Half-open window test: start <= coord < end on both axes.
  function automatic logic scissor_inside(
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y,
    input logic [COORD_W-1:0] start_x,
    input logic [COORD_W-1:0] start_y,
    input logic [COORD_W-1:0] end_x,
    input logic [COORD_W-1:0] end_y
  );
    return (x >= start_x) && (x < end_x) && (y >= start_y) && (y < end_y);
  endfunction

endpackage

// File: rtl/internal_framebuffer_stream_loader_if.sv
// rtl/internal_framebuffer_stream_loader_if.sv - pixel stream handshake into the framebuffer loader
interface internal_framebuffer_stream_loader_if #(
  parameter int STREAM_WIDTH = 64
);
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic                    s_axis_tlast;
  logic [STREAM_WIDTH-1:0] s_axis_tdata;

  modport master (
    output s_axis_tvalid,
    output s_axis_tlast,
    output s_axis_tdata,
    input  s_axis_tready
  );

  modport slave (
    input  s_axis_tvalid,
    input  s_axis_tlast,
    input  s_axis_tdata,
    output s_axis_tready
  );
endinterface

// File: rtl/internal_framebuffer_stream_loader_scissor.sv
// rtl/internal_framebuffer_stream_loader_scissor.sv - per-beat sub-pixel write mask (scissor clipping under RIX_FB_LOAD_SCISSOR_EN)
module internal_framebuffer_stream_loader_scissor
  import internal_framebuffer_stream_loader_pkg::*;
#(
  parameter int NUMBER_OF_PIXELS_PER_BEAT = 2,
  parameter int NUMBER_OF_SUB_PIXELS      = 4,
`ifdef RIX_FB_LOAD_SCISSOR_EN
  parameter int X_BIT_WIDTH               = 11,
  parameter int Y_BIT_WIDTH               = 11,
`endif
  localparam int MASK_WIDTH = NUMBER_OF_PIXELS_PER_BEAT * NUMBER_OF_SUB_PIXELS
) (
  input  logic [NUMBER_OF_SUB_PIXELS-1:0] conf_mask,
`ifdef RIX_FB_LOAD_SCISSOR_EN
  input  logic                            scissor_en,
  input  logic [X_BIT_WIDTH-1:0]          x,
  input  logic [Y_BIT_WIDTH-1:0]          y,
  input  logic [X_BIT_WIDTH-1:0]          start_x,
  input  logic [Y_BIT_WIDTH-1:0]          start_y,
  input  logic [X_BIT_WIDTH-1:0]          end_x,
  input  logic [Y_BIT_WIDTH-1:0]          end_y,
`endif
  output logic [MASK_WIDTH-1:0]           beat_mask
);

  // Replicate the sub-pixel enable per pixel, dropping pixels outside the window
  always_comb begin
    beat_mask = '0;
    for (int i = 0; i < NUMBER_OF_PIXELS_PER_BEAT; i++) begin
`ifdef RIX_FB_LOAD_SCISSOR_EN
      if (!scissor_en ||
          scissor_inside(COORD_W'(x) + COORD_W'(i), COORD_W'(y),
                         COORD_W'(start_x), COORD_W'(start_y),
                         COORD_W'(end_x), COORD_W'(end_y))) begin
        beat_mask[i*NUMBER_OF_SUB_PIXELS +: NUMBER_OF_SUB_PIXELS] = conf_mask;
      end
`else
      beat_mask[i*NUMBER_OF_SUB_PIXELS +: NUMBER_OF_SUB_PIXELS] = conf_mask;
`endif
    end
  end

endmodule

// File: rtl/internal_framebuffer_stream_loader.sv
// rtl/internal_framebuffer_stream_loader.sv - streams pixel beats into framebuffer RAM; scissor clipping under RIX_FB_LOAD_SCISSOR_EN
module internal_framebuffer_stream_loader
  import internal_framebuffer_stream_loader_pkg::*;
#(
  parameter int NUMBER_OF_PIXELS_PER_BEAT    = 2,
  parameter int NUMBER_OF_SUB_PIXELS         = 4,
  parameter int SUB_PIXEL_WIDTH              = 8,
  parameter int X_BIT_WIDTH                  = 11,
  parameter int Y_BIT_WIDTH                  = 11,
  parameter int FRAMEBUFFER_SIZE_IN_PIXEL_LG = 18,
  parameter int FB_SIZE_IN_PIXEL_LG          = 20,
  localparam int PIXEL_WIDTH    = NUMBER_OF_SUB_PIXELS * SUB_PIXEL_WIDTH,
  localparam int STREAM_WIDTH   = NUMBER_OF_PIXELS_PER_BEAT * PIXEL_WIDTH,
  localparam int MEM_WIDTH      = STREAM_WIDTH,
  localparam int MEM_MASK_WIDTH = NUMBER_OF_PIXELS_PER_BEAT * NUMBER_OF_SUB_PIXELS,
  localparam int BEAT_LG        = $clog2(NUMBER_OF_PIXELS_PER_BEAT),
  localparam int MEM_ADDR_WIDTH = FRAMEBUFFER_SIZE_IN_PIXEL_LG - BEAT_LG
) (
  input  logic                            aclk,
  input  logic                            resetn,
  input  logic                            confEnableScissor,
  input  logic [X_BIT_WIDTH-1:0]          confScissorStartX,
  input  logic [Y_BIT_WIDTH-1:0]          confScissorStartY,
  input  logic [X_BIT_WIDTH-1:0]          confScissorEndX,
  input  logic [Y_BIT_WIDTH-1:0]          confScissorEndY,
  input  logic [Y_BIT_WIDTH-1:0]          confYOffset,
  input  logic [X_BIT_WIDTH-1:0]          confXResolution,
  input  logic [Y_BIT_WIDTH-1:0]          confYResolution,
  input  logic [NUMBER_OF_SUB_PIXELS-1:0] confMask,
  output logic [MEM_WIDTH-1:0]            writeDataPort,
  output logic                            writeEnablePort,
  output logic [MEM_ADDR_WIDTH-1:0]       writeAddrPort,
  output logic [MEM_MASK_WIDTH-1:0]       writeMaskPort,
  input  logic                            apply,
  output logic                            applied,
  input  logic                            cmdLoad,
  input  logic [FB_SIZE_IN_PIXEL_LG-1:0]  cmdSize,
  output logic                            loadError,
  internal_framebuffer_stream_loader_if.slave s_axis
);

  fb_state_e                   state_q, state_d;
  logic                        applied_q, applied_d;
  logic                        tready_q, tready_d;
  logic                        load_error_q, load_error_d;
  logic [MEM_ADDR_WIDTH-1:0]   index_q, index_d;
  logic [MEM_ADDR_WIDTH-1:0]   size_q, size_d;
  logic                        wr_en_q, wr_en_d;
  logic [MEM_ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [STREAM_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic [MEM_MASK_WIDTH-1:0]   wr_mask_q, wr_mask_d;
  logic [MEM_MASK_WIDTH-1:0]   beat_mask;
  logic [MEM_ADDR_WIDTH-1:0]   cmd_beats;
  logic                        beat_ok;
  logic                        final_beat;
`ifdef RIX_FB_LOAD_SCISSOR_EN
  logic [X_BIT_WIDTH-1:0]      x_q, x_d;
  logic [Y_BIT_WIDTH-1:0]      y_q, y_d;
`endif

  // Sub-beat pixel counts are dropped; a full-RAM size truncates to 0 and is a no-op.
  assign cmd_beats  = cmdSize[BEAT_LG +: MEM_ADDR_WIDTH];
  assign beat_ok    = s_axis.s_axis_tvalid && tready_q;
  assign final_beat = (index_q + MEM_ADDR_WIDTH'(1)) == size_q;

  internal_framebuffer_stream_loader_scissor #(
    .NUMBER_OF_PIXELS_PER_BEAT (NUMBER_OF_PIXELS_PER_BEAT),
    .NUMBER_OF_SUB_PIXELS      (NUMBER_OF_SUB_PIXELS)
`ifdef RIX_FB_LOAD_SCISSOR_EN
   ,.X_BIT_WIDTH               (X_BIT_WIDTH),
    .Y_BIT_WIDTH               (Y_BIT_WIDTH)
`endif
  ) u_mask_gen (
    .conf_mask  (confMask),
`ifdef RIX_FB_LOAD_SCISSOR_EN
    .scissor_en (confEnableScissor),
    .x          (x_q),
    .y          (y_q),
    .start_x    (confScissorStartX),
    .start_y    (confScissorStartY),
    .end_x      (confScissorEndX),
    .end_y      (confScissorEndY),
`endif
    .beat_mask  (beat_mask)
  );

  // Command acceptance, beat accounting and next-state selection
  always_comb begin
    state_d      = state_q;
    applied_d    = applied_q;
    load_error_d = load_error_q;
    index_d      = index_q;
    size_d       = size_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_mask_d    = wr_mask_q;
`ifdef RIX_FB_LOAD_SCISSOR_EN
    x_d          = x_q;
    y_d          = y_q;
`endif
    case (state_q)
      FB_IDLE: begin
        index_d = '0;
        size_d  = cmd_beats;
`ifdef RIX_FB_LOAD_SCISSOR_EN
        // Rows are filled top-down, starting at the last row of the tile.
        x_d     = '0;
        y_d     = confYOffset + confYResolution - Y_BIT_WIDTH'(1);
`endif
        if (apply && cmdLoad) begin
          applied_d    = 1'b0;
          load_error_d = 1'b0;
          state_d      = (cmd_beats == '0) ? FB_IDLE : FB_LOAD;
        end else if (!apply) begin
          applied_d = 1'b1;
        end
      end
      FB_LOAD: begin
        if (beat_ok) begin
          wr_en_d   = 1'b1;
          wr_addr_d = index_q;
          wr_data_d = s_axis.s_axis_tdata;
          wr_mask_d = beat_mask;
          index_d   = index_q + MEM_ADDR_WIDTH'(1);
`ifdef RIX_FB_LOAD_SCISSOR_EN
          if (x_q + X_BIT_WIDTH'(NUMBER_OF_PIXELS_PER_BEAT) == confXResolution) begin
            x_d = '0;
            y_d = y_q - Y_BIT_WIDTH'(1);
          end else begin
            x_d = x_q + X_BIT_WIDTH'(NUMBER_OF_PIXELS_PER_BEAT);
          end
`endif
          if (s_axis.s_axis_tlast) begin
            // Early tlast keeps what was written and flags the short stream.
            state_d = FB_IDLE;
            if (!final_beat) begin
              load_error_d = 1'b1;
            end
          end else if (final_beat) begin
            // Stream is longer than the command; swallow the rest.
            load_error_d = 1'b1;
            state_d      = FB_DRAIN;
          end
        end
      end
      FB_DRAIN: begin
        if (beat_ok && s_axis.s_axis_tlast) begin
          state_d = FB_IDLE;
        end
      end
      default: state_d = FB_IDLE;
    endcase
    tready_d = (state_d != FB_IDLE);
  end

  // Control and write-port registers with asynchronous abort
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= FB_IDLE;
      applied_q    <= 1'b1;
      tready_q     <= 1'b0;
      load_error_q <= 1'b0;
      index_q      <= '0;
      size_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_mask_q    <= '0;
    end else begin
      state_q      <= state_d;
      applied_q    <= applied_d;
      tready_q     <= tready_d;
      load_error_q <= load_error_d;
      index_q      <= index_d;
      size_q       <= size_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_mask_q    <= wr_mask_d;
    end
  end

`ifdef RIX_FB_LOAD_SCISSOR_EN
  // Raster position of the next beat's first pixel
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end
`endif

  assign writeEnablePort      = wr_en_q;
  assign writeAddrPort        = wr_addr_q;
  assign writeDataPort        = wr_data_q;
  assign writeMaskPort        = wr_mask_q;
  assign applied              = applied_q;
  assign loadError            = load_error_q;
  assign s_axis.s_axis_tready = tready_q;

  // Sub-beat and out-of-range size bits, and scissor settings in the plain build, are ignored.
  logic unused_ok;
`ifdef RIX_FB_LOAD_SCISSOR_EN
  assign unused_ok = ^cmdSize;
`else
  assign unused_ok = ^{cmdSize, confEnableScissor, confScissorStartX, confScissorStartY,
                       confScissorEndX, confScissorEndY, confYOffset, confXResolution,
                       confYResolution};
`endif

endmodule

// File: tb/tb_internal_framebuffer_stream_loader.sv
// tb/tb_internal_framebuffer_stream_loader.sv - randomized self-checking bench with behavioural load model
module tb_internal_framebuffer_stream_loader;

  localparam int PPB = 2;
  localparam int NSP = 4;
  localparam int SW  = 64;
  localparam int MW  = 8;
  localparam int AW  = 17;
  localparam int FBW = 20;
  localparam int XW  = 11;
  localparam int YW  = 11;

  logic          aclk = 1'b0;
  logic          resetn = 1'b0;
  logic          conf_en = 1'b0;
  logic [XW-1:0] sx = '0, ex = '0, xres = 11'd4;
  logic [YW-1:0] sy = '0, ey = '0, yoff = '0, yres = 11'd2;
  logic [NSP-1:0] cmask = 4'hF;
  logic [SW-1:0] wdata;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [MW-1:0] wmask;
  logic          apply = 1'b0;
  logic          applied;
  logic          cmd_load = 1'b0;
  logic [FBW-1:0] cmd_size = '0;
  logic          load_error;

  internal_framebuffer_stream_loader_if #(.STREAM_WIDTH(SW)) s_if ();

  internal_framebuffer_stream_loader dut (
    .aclk              (aclk),
    .resetn            (resetn),
    .confEnableScissor (conf_en),
    .confScissorStartX (sx),
    .confScissorStartY (sy),
    .confScissorEndX   (ex),
    .confScissorEndY   (ey),
    .confYOffset       (yoff),
    .confXResolution   (xres),
    .confYResolution   (yres),
    .confMask          (cmask),
    .writeDataPort     (wdata),
    .writeEnablePort   (wen),
    .writeAddrPort     (waddr),
    .writeMaskPort     (wmask),
    .apply             (apply),
    .applied           (applied),
    .cmdLoad           (cmd_load),
    .cmdSize           (cmd_size),
    .loadError         (load_error),
    .s_axis            (s_if.slave)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected mask from the pixel's linear position within the load.
  function automatic logic [MW-1:0] exp_mask(input int beat);
    logic [MW-1:0] m = '0;
    for (int i = 0; i < PPB; i++) begin
      bit on = 1'b1;
`ifdef RIX_FB_LOAD_SCISSOR_EN
      if (conf_en) begin
        int p  = beat * PPB + i;
        int px = p % int'(xres);
        int py = int'(yoff) + int'(yres) - 1 - p / int'(xres);
        on = (px >= int'(sx)) && (px < int'(ex)) && (py >= int'(sy)) && (py < int'(ey));
      end
`endif
      if (on) m[i*NSP +: NSP] = cmask;
    end
    return m;
  endfunction

  // Behavioural model: mode 0 idle, 1 loading, 2 draining
  int            m_mode = 0;
  bit            m_applied = 1'b1;
  bit            m_err = 1'b0;
  bit            m_we = 1'b0;
  int            m_count = 0;
  int            m_size = 0;
  logic [AW-1:0] m_addr = '0;
  logic [SW-1:0] m_data = '0;
  logic [MW-1:0] m_mask = '0;

  always @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      m_mode = 0; m_applied = 1'b1; m_err = 1'b0; m_we = 1'b0; m_count = 0; m_size = 0;
    end else begin
      m_we = 1'b0;
      case (m_mode)
        0: begin
          if (apply && cmd_load) begin
            m_applied = 1'b0;
            m_err     = 1'b0;
            m_size    = (int'(cmd_size) / PPB) % (1 << AW);
            m_count   = 0;
            m_mode    = (m_size == 0) ? 0 : 1;
          end else if (!apply) begin
            m_applied = 1'b1;
          end
        end
        1: begin
          if (s_if.s_axis_tvalid) begin
            m_we    = 1'b1;
            m_addr  = AW'(m_count);
            m_data  = s_if.s_axis_tdata;
            m_mask  = exp_mask(m_count);
            m_count = m_count + 1;
            if (s_if.s_axis_tlast) begin
              if (m_count != m_size) m_err = 1'b1;
              m_mode = 0;
            end else if (m_count == m_size) begin
              m_err  = 1'b1;
              m_mode = 2;
            end
          end
        end
        default: begin
          if (s_if.s_axis_tvalid && s_if.s_axis_tlast) m_mode = 0;
        end
      endcase
    end
  end

  // Write log and per-cycle comparison against the model
  int            wr_total = 0;
  logic [AW-1:0] log_addr [256];
  logic [SW-1:0] log_data [256];
  logic [MW-1:0] log_mask [256];

  always @(negedge aclk) begin
    chk("tready", s_if.s_axis_tready, (m_mode != 0));
    chk("applied", applied, m_applied);
    chk("loadError", load_error, m_err);
    chk("wen", wen, m_we);
    if (m_we && wen) begin
      chk("waddr", waddr, m_addr);
      chk("wdata", wdata, m_data);
      chk("wmask", wmask, m_mask);
    end
    if (wen) begin
      log_addr[wr_total % 256] = waddr;
      log_data[wr_total % 256] = wdata;
      log_mask[wr_total % 256] = wmask;
      wr_total++;
    end
  end

  logic [SW-1:0] bdata [64];

  task automatic send_cmd(input logic [FBW-1:0] size, input logic load);
    @(negedge aclk);
    cmd_size = size;
    cmd_load = load;
    @(negedge aclk);
    apply = 1'b1;
    @(negedge aclk);
    apply    = 1'b0;
    cmd_load = 1'b0;
  endtask

  // bubble: 0 none, 1 tvalid low every other cycle, 2 random
  task automatic send_stream(input int n, input int last_idx, input int bubble);
    int b = 0;
    int cyc = 0;
    bit acc;
    while (b < n && cyc < 400) begin
      @(negedge aclk);
      if ((bubble == 1 && cyc % 2 == 1) || (bubble == 2 && $urandom_range(0, 2) == 0)) begin
        s_if.s_axis_tvalid = 1'b0;
      end else begin
        s_if.s_axis_tvalid = 1'b1;
        s_if.s_axis_tdata  = bdata[b];
        s_if.s_axis_tlast  = (b == last_idx);
      end
      acc = s_if.s_axis_tvalid && s_if.s_axis_tready;
      @(posedge aclk);
      if (acc) b++;
      cyc++;
    end
    chk("stream_done", (b == n), 1'b1);
    @(negedge aclk);
    s_if.s_axis_tvalid = 1'b0;
    s_if.s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_applied(input string name);
    int n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (applied !== 1'b1 && n < 50);
    chk({name, "_applied"}, applied, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int nb;
    int last;
    s_if.s_axis_tvalid = 1'b0;
    s_if.s_axis_tlast  = 1'b0;
    s_if.s_axis_tdata  = '0;
    repeat (3) @(negedge aclk);
    chk("rst_tready", s_if.s_axis_tready, 1'b0);
    chk("rst_applied", applied, 1'b1);
    chk("rst_wen", wen, 1'b0);
    chk("rst_loadError", load_error, 1'b0);
    resetn = 1'b1;
    repeat (2) @(negedge aclk);

    // Normal 4-beat load
    for (int i = 0; i < 4; i++) bdata[i] = SW'(i + 1);
    start = wr_total;
    send_cmd(20'd8, 1'b1);
    send_stream(4, 3, 0);
    wait_applied("normal");
    chk("normal_count", wr_total - start, 4);
    for (int i = 0; i < 4; i++) begin
      chk("normal_addr", log_addr[(start + i) % 256], i);
      chk("normal_data", log_data[(start + i) % 256], i + 1);
      chk("normal_mask", log_mask[(start + i) % 256], 8'hFF);
    end
    chk("normal_err", load_error, 1'b0);

    // Same load with tvalid toggling
    start = wr_total;
    send_cmd(20'd8, 1'b1);
    send_stream(4, 3, 1);
    wait_applied("bubble");
    chk("bubble_count", wr_total - start, 4);
    for (int i = 0; i < 4; i++) chk("bubble_data", log_data[(start + i) % 256], i + 1);

    // Early tlast on beat 2
    start = wr_total;
    send_cmd(20'd8, 1'b1);
    send_stream(2, 1, 0);
    wait_applied("early");
    chk("early_count", wr_total - start, 2);
    chk("early_last_addr", log_addr[(start + 1) % 256], 1);
    chk("early_err", load_error, 1'b1);

    // apply without cmdLoad leaves everything alone
    start = wr_total;
    send_cmd(20'd8, 1'b0);
    repeat (4) @(negedge aclk);
    chk("noload_count", wr_total - start, 0);
    chk("noload_err", load_error, 1'b1);

    // Overlong stream: 2-beat command, 5 beats
    for (int i = 0; i < 5; i++) bdata[i] = SW'(64'hA0 + i);
    start = wr_total;
    send_cmd(20'd4, 1'b1);
    send_stream(5, 4, 0);
    wait_applied("long");
    chk("long_count", wr_total - start, 2);
    chk("long_data", log_data[(start + 1) % 256], 64'hA1);
    chk("long_err", load_error, 1'b1);

    // Zero-beat commands: 0 pixels, sub-beat pixel count, full RAM wrapped to 0
    for (int k = 0; k < 3; k++) begin
      logic [FBW-1:0] sz;
      sz = (k == 0) ? 20'd0 : (k == 1) ? 20'd1 : 20'h40000;
      start = wr_total;
      send_cmd(sz, 1'b1);
      wait_applied("noop");
      chk("noop_count", wr_total - start, 0);
      chk("noop_err", load_error, 1'b0);
    end

    // Random loads with random tlast placement, mask and bubbles
    for (int t = 0; t < 12; t++) begin
      nb   = $urandom_range(1, 10);
      last = $urandom_range(0, nb + 2);
      cmask = 4'($urandom);
      for (int i = 0; i <= last; i++) bdata[i] = {$urandom, $urandom};
      start = wr_total;
      send_cmd(FBW'(nb * 2 + $urandom_range(0, 1)), 1'b1);
      send_stream(last + 1, last, 2);
      wait_applied("rand");
      chk("rand_count", wr_total - start, (last + 1 < nb) ? last + 1 : nb);
      chk("rand_err", load_error, (last + 1 != nb));
    end
    cmask = 4'hF;

`ifdef RIX_FB_LOAD_SCISSOR_EN
    // Scissor X[1,3) Y[0,2) over a 4x2 tile
    conf_en = 1'b1; sx = 11'd1; ex = 11'd3; sy = 11'd0; ey = 11'd2;
    xres = 11'd4; yres = 11'd2; yoff = 11'd0;
    for (int i = 0; i < 4; i++) bdata[i] = SW'(i + 16);
    start = wr_total;
    send_cmd(20'd8, 1'b1);
    send_stream(4, 3, 0);
    wait_applied("scissor");
    chk("scissor_count", wr_total - start, 4);
    chk("scissor_m0", log_mask[(start + 0) % 256], 8'hF0);
    chk("scissor_m1", log_mask[(start + 1) % 256], 8'h0F);
    chk("scissor_m2", log_mask[(start + 2) % 256], 8'hF0);
    chk("scissor_m3", log_mask[(start + 3) % 256], 8'h0F);
    conf_en = 1'b0;
`endif

    // Reset after the first beat of a 4-beat load
    start = wr_total;
    send_cmd(20'd8, 1'b1);
    @(negedge aclk);
    s_if.s_axis_tvalid = 1'b1;
    s_if.s_axis_tdata  = 64'hAA;
    s_if.s_axis_tlast  = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    #2 resetn = 1'b0;
    s_if.s_axis_tdata = 64'hBB;
    #1;
    chk("abort_tready", s_if.s_axis_tready, 1'b0);
    chk("abort_applied", applied, 1'b1);
    chk("abort_wen", wen, 1'b0);
    repeat (3) @(negedge aclk);
    resetn = 1'b1;
    repeat (4) @(negedge aclk);
    s_if.s_axis_tvalid = 1'b0;
    chk("abort_count", wr_total - start, 1);
    chk("abort_data", log_data[start % 256], 64'hAA);

    // Recovery load after the abort
    for (int i = 0; i < 2; i++) bdata[i] = SW'(i + 7);
    start = wr_total;
    send_cmd(20'd4, 1'b1);
    send_stream(2, 1, 0);
    wait_applied("recover");
    chk("recover_count", wr_total - start, 2);
    chk("recover_addr", log_addr[start % 256], 0);

    repeat (2) @(negedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
